pet_fsm_param: RTL and testbench

- Parametrised virtual-pet behaviour controller; next generation of the single-need hunger/proximity state logic.
- Tracks two needs (hunger, energy) with per-need second counters, a health score, and a death state.
- Edge-detects the two action buttons and times feeding/sleeping activities.
- Sits between the ultrasonic distance front end and the display/face-matrix drivers; its state code drives face selection.

---
 rtl/pet_pkg.sv | 16 +
 rtl/pet_tick_gen.sv | 22 ++
 rtl/pet_fsm_param.sv | 150 +++++++++++++++
 tb/tb_pet_fsm_param.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pet_pkg.sv
// Shared encodings for the virtual-pet controller: state codes and field widths.
`timescale 1ns/1ps
package pet_pkg;
  localparam int STATE_W  = 4;
  localparam int HEALTH_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 4'd0,
    ST_HUNGRY    = 4'd1,
    ST_TIRED     = 4'd2,
    ST_ATTENTION = 4'd3,
    ST_FEEDING   = 4'd4,
    ST_SLEEPING  = 4'd5,
    ST_DEAD      = 4'd6
  } pet_state_e;
endpackage

// File: rtl/pet_tick_gen.sv
// One-second tick prescaler; tick is high during the last count of each CLK_HZ period.
`timescale 1ns/1ps
module pet_tick_gen #(
  parameter int CLK_HZ = 50000000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);
  localparam int CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_HZ - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick  = (cnt_q == LAST);
  assign cnt_d = tick ? '0 : cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/pet_fsm_param.sv
// Virtual-pet behaviour controller: hunger/energy needs, health, activities and death.
`timescale 1ns/1ps
module pet_fsm_param
  import pet_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int TIME_W     = 12,
  parameter int DIST_W     = 16,
  parameter int NEAR_CM    = 5,
  parameter int HUNGER_S   = 60,
  parameter int TIRED_S    = 120,
  parameter int ATTN_S     = 10,
  parameter int FEED_S     = 3,
  parameter int SLEEP_S    = 20,
  parameter int NEGLECT_S  = 30,
  parameter int HEALTH_MAX = 7
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [DIST_W-1:0]   dist_cm,
  input  logic                dist_valid,
  input  logic [1:0]          act,
  output logic [STATE_W-1:0]  state,
  output logic [HEALTH_W-1:0] health,
  output logic [TIME_W-1:0]   seconds,
  output logic                tick_1hz,
  output logic                state_chg
);
  localparam logic [HEALTH_W-1:0] HMAX = HEALTH_W'(HEALTH_MAX);

  pet_state_e          state_q, state_d;
  logic [HEALTH_W-1:0] health_q, health_d;
  logic [TIME_W-1:0]   seconds_q, hunger_q, hunger_d, energy_q, energy_d;
  logic [TIME_W-1:0]   phase_q, phase_d, neglect_q, neglect_d;
  logic [1:0]          act_q, press_q;
  logic                state_chg_q;
  logic                tick, near, hungry, tired;

  function automatic logic [TIME_W-1:0] sat_inc(input logic [TIME_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic pet_state_e need_state(input logic is_hungry, input logic is_tired);
    if (is_hungry)     return ST_HUNGRY;
    else if (is_tired) return ST_TIRED;
    else               return ST_IDLE;
  endfunction

  pet_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  assign near   = enable & dist_valid & (dist_cm <= DIST_W'(NEAR_CM));
  assign hungry = (hunger_q >= TIME_W'(HUNGER_S));
  assign tired  = (energy_q >= TIME_W'(TIRED_S));

  // Transitions and counters all look at pre-tick register values.
  always_comb begin
    state_d   = state_q;
    health_d  = health_q;
    neglect_d = '0;
    if (state_q != ST_DEAD) begin
      if (health_q == '0 && state_q != ST_FEEDING && state_q != ST_SLEEPING) begin
        state_d = ST_DEAD;
      end else begin
        case (state_q)
          ST_IDLE, ST_HUNGRY, ST_TIRED: begin
            if (near)                  state_d = ST_ATTENTION;
            else if (state_q == ST_IDLE) state_d = need_state(hungry, tired);
          end
          ST_ATTENTION: begin
            if (press_q[0])                          state_d = ST_FEEDING;
            else if (press_q[1])                     state_d = ST_SLEEPING;
            else if (phase_q >= TIME_W'(ATTN_S))     state_d = need_state(hungry, tired);
          end
          ST_FEEDING: begin
            if (phase_q >= TIME_W'(FEED_S)) begin
              state_d  = ST_IDLE;
              health_d = (health_q >= HMAX) ? HMAX : health_q + 1'b1;
            end
          end
          ST_SLEEPING: begin
            if (phase_q >= TIME_W'(SLEEP_S) || press_q[1]) state_d = ST_IDLE;
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end

    // Neglect only accumulates while the pet stays in an unmet-need state.
    if ((state_q == ST_HUNGRY || state_q == ST_TIRED) && state_d == state_q) begin
      neglect_d = neglect_q;
      if (tick) begin
        if (sat_inc(neglect_q) >= TIME_W'(NEGLECT_S)) begin
          neglect_d = '0;
          health_d  = (health_q == '0) ? '0 : health_q - 1'b1;
        end else begin
          neglect_d = sat_inc(neglect_q);
        end
      end
    end

    if (state_q == ST_FEEDING || state_d == ST_FEEDING) hunger_d = '0;
    else if (tick)                                       hunger_d = sat_inc(hunger_q);
    else                                                 hunger_d = hunger_q;

    if (state_q == ST_SLEEPING || state_d == ST_SLEEPING) energy_d = '0;
    else if (tick)                                         energy_d = sat_inc(energy_q);
    else                                                   energy_d = energy_q;

    if (state_d != state_q) phase_d = '0;
    else if (tick)          phase_d = sat_inc(phase_q);
    else                    phase_d = phase_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      health_q    <= HMAX;
      seconds_q   <= '0;
      hunger_q    <= '0;
      energy_q    <= '0;
      phase_q     <= '0;
      neglect_q   <= '0;
      act_q       <= act;
      press_q     <= '0;
      state_chg_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      health_q    <= health_d;
      seconds_q   <= tick ? seconds_q + 1'b1 : seconds_q;
      hunger_q    <= hunger_d;
      energy_q    <= energy_d;
      phase_q     <= phase_d;
      neglect_q   <= neglect_d;
      act_q       <= act;
      press_q     <= act & ~act_q;
      state_chg_q <= (state_d != state_q);
    end
  end

  assign state     = state_q;
  assign health    = health_q;
  assign seconds   = seconds_q;
  assign tick_1hz  = tick;
  assign state_chg = state_chg_q;
endmodule

// File: tb/tb_pet_fsm_param.sv
// Bench for pet_fsm_param: directed scenarios plus random stimulus against a reference model.
`timescale 1ns/1ps
module tb_pet_fsm_param;
  localparam int CLK = 10, TW = 12, DW = 16, NEAR = 5;
  localparam int HS = 6, TS = 9, AS = 4, FS = 2, SS = 3, NS = 2, HM = 7;
  localparam int TMAX = (1 << TW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          dist_valid = 1'b0;
  logic [DW-1:0] dist_cm = '0;
  logic [1:0]    act = 2'b00;
  logic [3:0]    state;
  logic [2:0]    health;
  logic [TW-1:0] seconds;
  logic          tick_1hz, state_chg;

  int checks = 0;
  int failures = 0;

  // Reference model (spec-level quantities as plain integers).
  int m_pre, m_sec, m_hun, m_eng, m_ph, m_neg, m_hp, m_st;
  logic [1:0] m_pa, m_pr;
  bit m_chg;

  pet_fsm_param #(
    .CLK_HZ(CLK), .TIME_W(TW), .DIST_W(DW), .NEAR_CM(NEAR), .HUNGER_S(HS),
    .TIRED_S(TS), .ATTN_S(AS), .FEED_S(FS), .SLEEP_S(SS), .NEGLECT_S(NS),
    .HEALTH_MAX(HM)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .dist_cm(dist_cm),
    .dist_valid(dist_valid), .act(act), .state(state), .health(health),
    .seconds(seconds), .tick_1hz(tick_1hz), .state_chg(state_chg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > TMAX) ? TMAX : v;
  endfunction

  task automatic model_step();
    int ns, hpn, need;
    bit tk, nr;
    if (reset) begin
      m_pre = 0; m_sec = 0; m_hun = 0; m_eng = 0; m_ph = 0; m_neg = 0;
      m_hp = HM; m_st = 0; m_pr = 2'b00; m_pa = act; m_chg = 0;
      return;
    end
    tk   = (m_pre == CLK - 1);
    nr   = enable && dist_valid && (dist_cm <= NEAR);
    need = (m_hun >= HS) ? 1 : ((m_eng >= TS) ? 2 : 0);
    ns   = m_st;
    hpn  = m_hp;
    if (m_st == 6) ns = 6;
    else if (m_hp == 0 && m_st != 4 && m_st != 5) ns = 6;
    else if (m_st <= 2 && nr) ns = 3;
    else if (m_st == 0) ns = need;
    else if (m_st == 3) begin
      if (m_pr[0]) ns = 4;
      else if (m_pr[1]) ns = 5;
      else if (m_ph >= AS) ns = need;
    end else if (m_st == 4) begin
      if (m_ph >= FS) begin ns = 0; hpn = (m_hp + 1 > HM) ? HM : m_hp + 1; end
    end else if (m_st == 5) begin
      if (m_ph >= SS || m_pr[1]) ns = 0;
    end
    if ((m_st == 1 || m_st == 2) && ns == m_st) begin
      if (tk) begin
        if (m_neg + 1 >= NS) begin m_neg = 0; hpn = (m_hp > 0) ? m_hp - 1 : 0; end
        else m_neg = sat(m_neg + 1);
      end
    end else m_neg = 0;
    m_hun = (m_st == 4 || ns == 4) ? 0 : sat(m_hun + int'(tk));
    m_eng = (m_st == 5 || ns == 5) ? 0 : sat(m_eng + int'(tk));
    m_ph  = (ns != m_st) ? 0 : sat(m_ph + int'(tk));
    m_sec = (m_sec + int'(tk)) % (TMAX + 1);
    m_pre = tk ? 0 : m_pre + 1;
    m_pr  = act & ~m_pa;
    m_pa  = act;
    m_chg = (ns != m_st);
    m_st  = ns;
    m_hp  = hpn;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check("m_state", state, m_st);
    check("m_health", health, m_hp);
    check("m_seconds", seconds, m_sec);
    check("m_tick", tick_1hz, (m_pre == CLK - 1));
    check("m_state_chg", state_chg, m_chg);
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    run(n);
    reset = 1'b0;
  endtask

  task automatic wait_tick();
    int n = 0;
    while (!tick_1hz && n < 12) begin cyc(); n++; end
    check("tick_seen", tick_1hz, 1);
  endtask

  task automatic first_tick_check(input string tag);
    int first = -1;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      if (tick_1hz && first < 0) first = k + 1;
      if (k == 10) check({tag, "_sec1"}, seconds, 1);
    end
    check({tag, "_first_tick_cycle"}, first, 10);
  endtask

  task automatic go_attention();
    enable = 1'b1; dist_valid = 1'b1; dist_cm = 16'd2;
    cyc();
    enable = 1'b0;
    check("attention_entry", state, 3);
  endtask

  initial begin
    int n, tk, bad;

    // Reset values and tick cadence, then HUNGRY after six ticks.
    reset = 1'b1;
    run(2);
    check("rst_state", state, 0);
    check("rst_health", health, 7);
    check("rst_seconds", seconds, 0);
    check("rst_tick", tick_1hz, 0);
    check("rst_chg", state_chg, 0);
    reset = 1'b0;
    first_tick_check("t1");
    run(48);
    check("idle_before_tick6", state, 0);
    cyc();
    check("hungry_after_tick6", state, 1);
    check("chg_pulse", state_chg, 1);
    cyc();
    check("chg_one_cycle", state_chg, 0);

    // Near at the 5 cm boundary, feed, saturated health, 6 cm is far.
    enable = 1'b1; dist_valid = 1'b1; dist_cm = 16'd5;
    cyc();
    check("near_5cm_attention", state, 3);
    dist_cm = 16'd100; act = 2'b01;
    run(2);
    check("feed_entry", state, 4);
    act = 2'b00;
    n = 0; tk = 0;
    while (state == 4 && n < 40) begin
      if (tick_1hz) tk++;
      cyc(); n++;
    end
    check("feed_ticks", tk, 2);
    check("feed_exit_idle", state, 0);
    check("feed_health_sat", health, 7);
    dist_cm = 16'd6; bad = 0;
    for (int k = 0; k < 50; k++) begin
      cyc();
      if (state == 3 || state == 1) bad = 1;
    end
    check("far6_and_hunger_cleared", bad, 0);

    // Neglect drains health one step per two ticks, then DEAD is sticky.
    enable = 1'b0;
    do_reset(2);
    run(61);
    check("neglect_hungry", state, 1);
    for (int k = 1; k <= 14; k++) begin
      wait_tick();
      cyc();
      check("neglect_health", health, 7 - k / 2);
    end
    cyc();
    check("dead", state, 6);
    enable = 1'b1; dist_valid = 1'b1; dist_cm = 16'd0;
    act = 2'b01; run(3); act = 2'b00; run(3); act = 2'b10; run(3); act = 2'b00; run(11);
    check("dead_sticky", state, 6);
    check("dead_health", health, 0);
    enable = 1'b0;
    reset = 1'b1;
    cyc();
    check("dead_reset_state", state, 0);
    check("dead_reset_health", health, 7);
    reset = 1'b0;

    // Simultaneous presses pick FEEDING; ATTENTION timeout falls back to HUNGRY.
    go_attention();
    act = 2'b11;
    run(2);
    check("both_press_feed", state, 4);
    act = 2'b00;
    do_reset(2);
    run(61);
    check("hungry_again", state, 1);
    go_attention();
    n = 0; tk = 0;
    while (state == 3 && n < 60) begin
      if (tick_1hz) tk++;
      cyc(); n++;
    end
    check("attn_timeout_ticks", tk, 4);
    check("attn_timeout_hungry", state, 1);

    // Early wake from SLEEPING, then a button held through reset.
    do_reset(2);
    go_attention();
    act = 2'b10;
    run(2);
    check("sleep_entry", state, 5);
    act = 2'b00;
    wait_tick();
    cyc();
    act = 2'b10;
    run(2);
    check("early_wake_idle", state, 0);
    reset = 1'b1;
    run(2);
    reset = 1'b0;
    go_attention();
    run(5);
    check("held_btn_no_press", state, 3);
    act = 2'b00;

    // Reset in the middle of FEEDING.
    run(2);
    act = 2'b01;
    run(2);
    check("feed_mid_entry", state, 4);
    act = 2'b00;
    run(5);
    check("feed_mid", state, 4);
    reset = 1'b1;
    cyc();
    check("mid_reset_state", state, 0);
    check("mid_reset_health", health, 7);
    check("mid_reset_seconds", seconds, 0);
    reset = 1'b0;
    first_tick_check("t6");

    // Random traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      reset      = ($urandom_range(0, 599) == 0);
      enable     = ($urandom_range(0, 3) != 0);
      dist_valid = ($urandom_range(0, 3) != 0);
      dist_cm    = ($urandom_range(0, 15) == 0) ? DW'($urandom_range(0, 6))
                                                : DW'($urandom_range(6, 1000));
      if ($urandom_range(0, 19) == 0) act[0] = ~act[0];
      if ($urandom_range(0, 19) == 0) act[1] = ~act[1];
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
